timekeeper: RTL and testbench
=============================

TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 1000: input clock frequency in Hz; legal range 2 to 2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 32: prescaler counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port select, input, 2 bits: edit field select; 0 = none, 1 = sec, 2 = min, 3 = hour.
REQ-006 SHALL have port inc, input, 1 bit: increment request; acts on its rising edge only.
REQ-007 SHALL have port dec, input, 1 bit: decrement request; acts on its rising edge only.
REQ-008 SHALL have port mode_12h, input, 1 bit: display mode; 1 = 12-hour, 0 = 24-hour.
REQ-009 SHALL have port alarm_set, input, 1 bit: when high, loads alarm_hour_in/alarm_min_in and arms the alarm.
REQ-010 SHALL have port alarm_hour_in, input, 5 bits: alarm hour, 0-23.
REQ-011 SHALL have port alarm_min_in, input, 6 bits: alarm minute, 0-59.
REQ-012 SHALL have port alarm_ack, input, 1 bit: clears alarm_out.
REQ-013 SHALL have port sec_out, output, 6 bits: seconds, 0-59.
REQ-014 SHALL have port min_out, output, 6 bits: minutes, 0-59.
REQ-015 SHALL have port hour_out, output, 5 bits: internal hour, 0-23.
REQ-016 SHALL have port disp_hour, output, 5 bits: displayed hour, 1-12 in 12h mode, 0-23 in 24h mode.
REQ-017 SHALL have port pm, output, 1 bit: 1 when hour_out >= 12.
REQ-018 SHALL have port tick_1hz, output, 1 bit: one-cycle pulse per second.
REQ-019 SHALL have port alarm_out, output, 1 bit: alarm active.

Function
REQ-020 Prescaler SHALL count 0..CLK_FREQ_HZ-1 and wrap; tick_1hz is high exactly in the cycle the prescaler equals CLK_FREQ_HZ-1, i.e. one tick per CLK_FREQ_HZ cycles.
REQ-021 On tick, sec SHALL advance; 59->0 carries to min; min 59->0 carries to hour; hour 23->0; results visible the cycle after the tick.
REQ-022 inc/dec edges SHALL be detected against a registered previous value; an edge present in cycle N updates outputs at N+1.
REQ-023 inc and dec edges in the same cycle SHALL be ignored, and so SHALL any edge with select = 0.
REQ-024 select = sec with an inc or dec edge SHALL clear sec to 0 and the prescaler to 0, and SHALL suppress any tick in that cycle.
REQ-025 select = min: inc wraps 59->0, dec wraps 0->59, with no carry or borrow into hour.
REQ-026 select = hour: inc wraps 23->0, dec wraps 0->23.
REQ-027 When an edit coincides with a tick, the selected field SHALL take the edit result; non-selected fields SHALL take their tick result, with carries computed from pre-edit values.
REQ-028 disp_hour and pm SHALL be combinational from hour_out: in 12h mode 0->12, 13-23 -> hour-12, otherwise unchanged; in 24h mode disp_hour = hour_out. mode_12h SHALL NOT alter stored time.

Reset
REQ-029 With reset high at a clock edge, the block SHALL set sec/min/hour = 0, prescaler = 0, previous inc/dec registers = 0, tick_1hz = 0, alarm_out = 0, alarm disarmed, alarm time = 00:00.
REQ-030 Reset SHALL take priority over tick, edit and alarm events in the same cycle.
REQ-031 Outputs after reset SHALL read disp_hour = 12, pm = 0 in 12h mode; disp_hour = 0 in 24h mode.

Configuration
REQ-032 Macro TIMEKEEPER_ALARM_EN, when defined, SHALL compile in the alarm registers and logic.
REQ-033 With TIMEKEEPER_ALARM_EN defined: alarm_set loads and arms the alarm in the next cycle.
- alarm_out sets when a tick moves time to alarm_hour:alarm_min:00 while armed.
- alarm_out clears on alarm_ack high, or once min_out differs from the alarm minute.
- ack beats set in the same cycle.
- Edits that land on the alarm time SHALL NOT trigger the alarm.
REQ-034 Without TIMEKEEPER_ALARM_EN: all alarm ports remain present, alarm inputs are ignored, and alarm_out is constant 0.

Verification (CLK_FREQ_HZ = 4)
REQ-035 Reset, then run 12 cycles -> tick_1hz high in cycles 3, 7 and 11; sec_out = 3.
REQ-036 Preload 23:59:59, then one tick -> 00:00:00 the next cycle; 12h mode shows disp_hour = 12, pm = 0.
REQ-037 select = min, min = 0, dec edge -> min = 59, hour unchanged; inc and dec edges together -> no change.
REQ-038 select = sec, inc edge in the same cycle as a tick -> sec = 0, prescaler = 0, no min carry; next tick 4 cycles later.
REQ-039 (ALARM_EN) alarm_set with 07:30, time 07:29:59, tick -> alarm_out = 1; alarm_ack -> 0; without ALARM_EN -> alarm_out stays 0.
REQ-040 Assert reset mid-edit (hour = 13, inc high) -> all zero next cycle, and no edge acted on after reset release while inc stays high.

Source files
------------

// File: rtl/timekeeper.sv
// timekeeper -- real-time clock with HH:MM:SS counters, field editing and an
// optional alarm.
//
// A prescaler divides clk down to a one-cycle tick_1hz pulse once every
// CLK_FREQ_HZ cycles. Each tick advances the time of day. Rising edges on
// inc/dec edit the field chosen by select.
//
// Optional feature macro: TIMEKEEPER_ALARM_EN
//   Defined   : alarm registers and match/acknowledge logic are built.
//   Undefined : the alarm ports remain, their inputs are ignored and
//               alarm_out is tied low.
//
// Ports
//   clk            i  clock; all state updates on its rising edge
//   reset          i  synchronous, active-high reset
//   select_i..     -- (names fixed by the interface, see below)
//   select         i  [1:0] edit field: 0 none, 1 sec, 2 min, 3 hour
//   inc / dec      i  edit requests, acted on at their rising edge only
//   mode_12h       i  1 = 12-hour display, 0 = 24-hour display
//   alarm_set      i  load alarm_hour_in/alarm_min_in and arm the alarm
//   alarm_hour_in  i  [4:0] alarm hour 0-23
//   alarm_min_in   i  [5:0] alarm minute 0-59
//   alarm_ack      i  clears alarm_out
//   sec_out        o  [5:0] seconds 0-59
//   min_out        o  [5:0] minutes 0-59
//   hour_out       o  [4:0] internal hour 0-23
//   disp_hour      o  [4:0] displayed hour (1-12 or 0-23)
//   pm             o  hour_out >= 12
//   tick_1hz       o  one-cycle pulse per second
//   alarm_out      o  alarm active
module timekeeper #(
  parameter int unsigned CLK_FREQ_HZ = 1000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] select,
  input  logic       inc,
  input  logic       dec,
  input  logic       mode_12h,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour_in,
  input  logic [5:0] alarm_min_in,
  input  logic       alarm_ack,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       tick_1hz,
  output logic       alarm_out
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(CLK_FREQ_HZ - 1);
  localparam logic [1:0] SEL_SEC  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_HOUR = 2'd3;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             inc_prev_q, dec_prev_q;
  // Set by reset, cleared one cycle later. Blocks edge detection in the first
  // cycle after release so a button held through reset is not seen as a new
  // press while the previous-value registers still hold their reset zeros.
  logic             first_q;

  logic inc_edge, dec_edge, edit, sec_edit, min_edit, hour_edit;
  logic presc_hit, tick;

  assign inc_edge  = inc & ~inc_prev_q & ~first_q;
  assign dec_edge  = dec & ~dec_prev_q & ~first_q;
  // Simultaneous inc/dec edges cancel; select = 0 means no field is editable.
  assign edit      = (inc_edge ^ dec_edge) && (select != 2'd0);
  assign sec_edit  = edit && (select == SEL_SEC);
  assign min_edit  = edit && (select == SEL_MIN);
  assign hour_edit = edit && (select == SEL_HOUR);

  assign presc_hit = (presc_q == PRESC_MAX);
  // A seconds edit restarts the second, so it swallows a coincident tick.
  assign tick      = presc_hit & ~sec_edit & ~reset;

  // Next-state: tick advance first (carries from pre-edit values), then the
  // selected field is overridden by its edit result.
  always_comb begin
    presc_d = presc_hit ? '0 : presc_q + CNT_W'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (tick) begin
      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      if (sec_q == 6'd59) begin
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        if (min_q == 6'd59) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
    end
    if (sec_edit) begin
      sec_d   = 6'd0;
      presc_d = '0;
    end
    if (min_edit) begin
      if (inc_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      else          min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
    end
    if (hour_edit) begin
      if (inc_edge) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      else          hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      inc_prev_q <= inc;
      dec_prev_q <= dec;
      first_q    <= 1'b0;
    end
  end

  assign sec_out  = sec_q;
  assign min_out  = min_q;
  assign hour_out = hour_q;
  assign tick_1hz = tick;

  // Display mapping only; stored time is always 24-hour.
  always_comb begin
    pm        = (hour_q >= 5'd12);
    disp_hour = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0)       disp_hour = 5'd12;
      else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
    end
  end

`ifdef TIMEKEEPER_ALARM_EN
  logic       armed_q;
  logic [4:0] al_hour_q;
  logic [5:0] al_min_q;
  logic       alarm_q;
  logic       alarm_hit;

  // Only a clock tick can trigger; any edit in the same cycle disqualifies it.
  assign alarm_hit = tick & ~edit & armed_q & (sec_d == 6'd0) &
                     (min_d == al_min_q) & (hour_d == al_hour_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q   <= 1'b0;
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      alarm_q   <= 1'b0;
    end else begin
      if (alarm_set) begin
        armed_q   <= 1'b1;
        al_hour_q <= alarm_hour_in;
        al_min_q  <= alarm_min_in;
      end
      // Acknowledge wins over a new trigger; a trigger wins over the
      // minute-mismatch auto-clear (the pre-tick minute differs by design).
      if (alarm_ack)               alarm_q <= 1'b0;
      else if (alarm_hit)          alarm_q <= 1'b1;
      else if (min_q != al_min_q)  alarm_q <= 1'b0;
    end
  end

  assign alarm_out = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_set, alarm_hour_in, alarm_min_in, alarm_ack};
  assign alarm_out    = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper.sv
// Testbench for timekeeper with CLK_FREQ_HZ = 4. A driver issues directed and
// random stimulus; for each cycle it pushes the expected outputs (from a
// seconds-of-day reference model) into a queue, and a monitor on the falling
// edge pops and compares them against the DUT.
module tb_timekeeper;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, inc, dec, mode_12h, alarm_set, alarm_ack;
  logic [1:0] select;
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic [5:0] sec_out, min_out;
  logic [4:0] hour_out, disp_hour;
  logic       pm, tick_1hz, alarm_out;

  timekeeper #(.CLK_FREQ_HZ(N), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .select(select), .inc(inc), .dec(dec),
    .mode_12h(mode_12h), .alarm_set(alarm_set), .alarm_hour_in(alarm_hour_in),
    .alarm_min_in(alarm_min_in), .alarm_ack(alarm_ack), .sec_out(sec_out),
    .min_out(min_out), .hour_out(hour_out), .disp_hour(disp_hour), .pm(pm),
    .tick_1hz(tick_1hz), .alarm_out(alarm_out)
  );

  typedef struct {
    int sec; int min; int hour; int disp; int pm; int tick; int alarm;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: time kept as seconds-of-day.
  int m_t, m_presc, m_pinc, m_pdec, m_first, m_armed, m_ah, m_am, m_alarm;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic int disp_of(input int h, input int md);
    if (md == 0) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  function automatic void edges(output int ie, output int de, output int ed, output int sed);
    ie  = (inc && !m_pinc && !m_first) ? 1 : 0;
    de  = (dec && !m_pdec && !m_first) ? 1 : 0;
    ed  = (ie != de && select != 2'd0) ? 1 : 0;
    sed = (ed != 0 && select == 2'd1) ? 1 : 0;
  endfunction

  task automatic push();
    exp_t e;
    int ie, de, ed, sed, h;
    edges(ie, de, ed, sed);
    h       = m_t / 3600;
    e.sec   = m_t % 60;
    e.min   = (m_t / 60) % 60;
    e.hour  = h;
    e.disp  = disp_of(h, int'(mode_12h));
    e.pm    = (h >= 12) ? 1 : 0;
    e.tick  = (m_presc == N - 1 && !reset && sed == 0) ? 1 : 0;
    e.alarm = m_alarm;
    q.push_back(e);
  endtask

  task automatic advance();
    int ie, de, ed, sed, h, m, tk, tn, hn, mn, sn, trig;
    edges(ie, de, ed, sed);
    if (reset) begin
      m_t = 0; m_presc = 0; m_pinc = 0; m_pdec = 0; m_first = 1;
      m_armed = 0; m_ah = 0; m_am = 0; m_alarm = 0;
    end else begin
      h  = m_t / 3600;
      m  = (m_t / 60) % 60;
      tk = (m_presc == N - 1 && sed == 0) ? 1 : 0;
      tn = (tk != 0) ? (m_t + 1) % 86400 : m_t;
      hn = tn / 3600; mn = (tn / 60) % 60; sn = tn % 60;
      if (ed != 0) begin
        case (select)
          2'd1: sn = 0;
          2'd2: mn = (m + ((ie != 0) ? 1 : 59)) % 60;
          default: hn = (h + ((ie != 0) ? 1 : 23)) % 24;
        endcase
      end
      m_presc = (sed != 0) ? 0 : (m_presc + 1) % N;
`ifdef TIMEKEEPER_ALARM_EN
      trig = (tk != 0 && ed == 0 && m_armed != 0 && hn == m_ah && mn == m_am && sn == 0) ? 1 : 0;
      if (alarm_ack)      m_alarm = 0;
      else if (trig != 0) m_alarm = 1;
      else if (m != m_am) m_alarm = 0;
      if (alarm_set) begin
        m_armed = 1; m_ah = int'(alarm_hour_in); m_am = int'(alarm_min_in);
      end
`else
      trig = 0;
      m_alarm = trig;
`endif
      m_t = hn * 3600 + mn * 60 + sn;
      m_pinc = int'(inc); m_pdec = int'(dec); m_first = 0;
    end
  endtask

  task automatic cyc();
    push();
    @(posedge clk);
    #2;
    advance();
  endtask

  task automatic edit(input int sel, input int up);
    select = 2'(sel);
    inc = (up != 0); dec = (up == 0);
    cyc();
    inc = 1'b0; dec = 1'b0;
    cyc();
    select = 2'd0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sec_out",   int'(sec_out),   e.sec);
      chk("min_out",   int'(min_out),   e.min);
      chk("hour_out",  int'(hour_out),  e.hour);
      chk("disp_hour", int'(disp_hour), e.disp);
      chk("pm",        int'(pm),        e.pm);
      chk("tick_1hz",  int'(tick_1hz),  e.tick);
      chk("alarm_out", int'(alarm_out), e.alarm);
    end
  end

  initial begin
    reset = 1'b1; inc = 1'b0; dec = 1'b0; mode_12h = 1'b0; select = 2'd0;
    alarm_set = 1'b0; alarm_ack = 1'b0; alarm_hour_in = 5'd0; alarm_min_in = 6'd0;
    @(posedge clk);
    #2;
    advance();
    reset = 1'b0;

    // Free-running after reset: ticks at cycles 3, 7, 11.
    repeat (12) cyc();

    // Preload 23:59:59 and roll over to midnight in 12h mode.
    edit(3, 0);
    edit(2, 0);
    edit(1, 1);
    for (int i = 0; i < 400 && !(m_t == 86399 && m_presc == N - 1); i++) cyc();
    mode_12h = 1'b1;
    repeat (3) cyc();

    // Minute wrap down without borrow; simultaneous inc+dec ignored.
    edit(2, 0);
    select = 2'd2; inc = 1'b1; dec = 1'b1;
    cyc();
    inc = 1'b0; dec = 1'b0;
    cyc();
    select = 2'd0;

    // Seconds edit coinciding with a tick.
    for (int i = 0; i < 8 && m_presc != N - 1; i++) cyc();
    select = 2'd1; inc = 1'b1;
    cyc();
    inc = 1'b0; select = 2'd0;
    repeat (9) cyc();

    // Alarm at 07:30 reached from 07:29:59.
    mode_12h = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    alarm_set = 1'b1; alarm_hour_in = 5'd7; alarm_min_in = 6'd30;
    cyc();
    alarm_set = 1'b0;
    repeat (7) edit(3, 1);
    repeat (29) edit(2, 1);
    edit(1, 1);
    for (int i = 0; i < 400 && !(m_t == 7 * 3600 + 29 * 60 + 59 && m_presc == N - 1); i++) cyc();
    repeat (4) cyc();
    alarm_ack = 1'b1; cyc(); alarm_ack = 1'b0;
    repeat (4) cyc();

    // Reset mid-edit with inc held through and after release.
    repeat (6) edit(3, 1);
    select = 2'd3; inc = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (4) cyc();
    inc = 1'b0;
    cyc();
    select = 2'd0;

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      select        = 2'($urandom_range(0, 3));
      inc           = ($urandom_range(0, 2) == 0);
      dec           = ($urandom_range(0, 2) == 0);
      mode_12h      = 1'($urandom_range(0, 1));
      alarm_set     = ($urandom_range(0, 49) == 0);
      alarm_hour_in = 5'($urandom_range(0, 23));
      alarm_min_in  = 6'($urandom_range(0, 59));
      alarm_ack     = ($urandom_range(0, 29) == 0);
      cyc();
    end
    reset = 1'b0; inc = 1'b0; dec = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
    cyc();

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
